// File: rtl/formula_2_sched_pkg.sv
// Shared types for the resource-shared isqrt formula evaluator.
//   pass_e     : which square root a job is on (C first, then B, then A)
//   sideband_t : per-job state that travels beside the isqrt pipeline
//   lat()      : acceptance-to-result latency in cycles for a given isqrt depth
package formula_2_sched_pkg;

  typedef enum logic [1:0] {
    PASS_C = 2'd0,
    PASS_B = 2'd1,
    PASS_A = 2'd2
  } pass_e;

  typedef struct packed {
    logic        vld;
    pass_e       pass;
    logic [31:0] a;
    logic [31:0] b;
  } sideband_t;

  // Three trips through (issue register + pipeline), plus the output register.
  function automatic int unsigned lat(input int unsigned n);
    return 3 * (n + 1) + 1;
  endfunction

endpackage

// File: rtl/formula_2_isqrt_sched_isqrt.sv
// Pipelined integer square root: y = floor(sqrt(arg)).
// The 16 digit-recurrence steps are spread over n_pipe_stages register stages,
// so y_vld follows arg_vld by exactly n_pipe_stages cycles.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   arg_vld, arg   : operand in
//   y_vld, y       : 16-bit root out
module formula_2_isqrt_sched_isqrt #(
  parameter int unsigned n_pipe_stages = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arg_vld,
  input  logic [31:0] arg,
  output logic        y_vld,
  output logic [15:0] y
);

  logic        vld_q  [n_pipe_stages];
  logic [31:0] op_q   [n_pipe_stages];
  logic [31:0] root_q [n_pipe_stages];

  for (genvar s = 0; s < n_pipe_stages; s++) begin : g_stage
    localparam int unsigned First = (s * 16) / n_pipe_stages;
    localparam int unsigned Last  = ((s + 1) * 16) / n_pipe_stages;

    logic        vld_in;
    logic [31:0] op_in, root_in, op_d, root_d, one;

    if (s == 0) begin : g_head
      assign vld_in  = arg_vld;
      assign op_in   = arg;
      assign root_in = '0;
    end else begin : g_body
      assign vld_in  = vld_q[s-1];
      assign op_in   = op_q[s-1];
      assign root_in = root_q[s-1];
    end

    // Remainder/root recurrence; 'one' walks down from 2^30 by powers of four.
    always_comb begin
      one    = '0;
      op_d   = op_in;
      root_d = root_in;
      for (int unsigned k = First; k < Last; k++) begin
        one = 32'd1 << (30 - 2 * k);
        if (op_d >= root_d + one) begin
          op_d   = op_d - (root_d + one);
          root_d = (root_d >> 1) + one;
        end else begin
          root_d = root_d >> 1;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q[s]  <= 1'b0;
        op_q[s]   <= '0;
        root_q[s] <= '0;
      end else begin
        vld_q[s]  <= vld_in;
        op_q[s]   <= op_d;
        root_q[s] <= root_d;
      end
    end
  end

  assign y_vld = vld_q[n_pipe_stages-1];
  assign y     = root_q[n_pipe_stages-1][15:0];

  logic unused_tail;
  assign unused_tail = ^{op_q[n_pipe_stages-1], root_q[n_pipe_stages-1][31:16]};

endmodule

// File: rtl/formula_2_isqrt_sched.sv
// Evaluates res = isqrt(a + isqrt(b + isqrt(c))) with one shared pipelined isqrt.
// Each job passes through the isqrt three times; recirculation has priority over
// new jobs, so arg_rdy drops whenever a job returns needing another pass.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   arg_vld, arg_rdy  : job handshake; a, b, c sampled on acceptance
//   res_vld, res      : one-cycle result pulse, zero-extended 16-bit root
//   busy              : a job is in flight or in the output register
module formula_2_isqrt_sched
  import formula_2_sched_pkg::*;
#(
  parameter int unsigned N_PIPE_STAGES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arg_vld,
  output logic        arg_rdy,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  output logic        res_vld,
  output logic [31:0] res,
  output logic        busy
);

  localparam int unsigned CntW = $clog2(N_PIPE_STAGES + 3);

  logic [31:0]     x_q, x_d;
  sideband_t       issue_q, issue_d;
  sideband_t       sb_q [N_PIPE_STAGES];
  sideband_t       sb_out;
  logic            y_vld;
  logic [15:0]     y;
  logic            recirc, accept;
  logic [CntW-1:0] inflight_q;

  formula_2_isqrt_sched_isqrt #(
    .n_pipe_stages(N_PIPE_STAGES)
  ) u_isqrt (
    .clk    (clk),
    .rst    (rst),
    .arg_vld(issue_q.vld),
    .arg    (x_q),
    .y_vld  (y_vld),
    .y      (y)
  );

  assign sb_out  = sb_q[N_PIPE_STAGES-1];
  assign recirc  = y_vld && (sb_out.pass != PASS_A);
  assign arg_rdy = !recirc;
  assign accept  = arg_vld && arg_rdy;

  always_comb begin
    x_d     = c;
    issue_d = '0;
    if (recirc) begin
      issue_d.vld = 1'b1;
      issue_d.a   = sb_out.a;
      issue_d.b   = sb_out.b;
      if (sb_out.pass == PASS_C) begin
        issue_d.pass = PASS_B;
        x_d          = {16'd0, y} + sb_out.b;
      end else begin
        issue_d.pass = PASS_A;
        x_d          = {16'd0, y} + sb_out.a;
      end
    end else if (accept) begin
      issue_d.vld  = 1'b1;
      issue_d.pass = PASS_C;
      issue_d.a    = a;
      issue_d.b    = b;
      x_d          = c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q     <= '0;
      issue_q <= '0;
      for (int i = 0; i < N_PIPE_STAGES; i++) sb_q[i] <= '0;
    end else begin
      x_q     <= x_d;
      issue_q <= issue_d;
      // Delay line matches the isqrt depth so sb_out lines up with y.
      sb_q[0] <= issue_q;
      for (int i = 1; i < N_PIPE_STAGES; i++) sb_q[i] <= sb_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_vld <= 1'b0;
      res     <= '0;
    end else begin
      res_vld <= y_vld && (sb_out.pass == PASS_A);
      if (y_vld && (sb_out.pass == PASS_A)) res <= {16'd0, y};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= '0;
    end else if (accept && !res_vld) begin
      inflight_q <= inflight_q + CntW'(1);
    end else if (!accept && res_vld) begin
      inflight_q <= inflight_q - CntW'(1);
    end
  end

  assign busy = (inflight_q != '0);

endmodule
